shifter_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one 32-bit barrel shifter (`SHIFTER_32`) between two requesters, e.g. the ALU shift path and a multi-cycle multiply/divide helper. Each requester issues {operand, amount, arith, right} with a valid/ready handshake. The arbiter grants one request per cycle, drives the shared shifter, and registers the result into a single output slot with its own valid/ready handshake and requester tag. The block sits between the execute-stage requesters and the shared shifter instance.

---
 rtl/shifter_arbiter.sv | 99 +++++++++
 tb/tb_shifter_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shifter_arbiter
// Description : Two-port round-robin arbiter sharing one 32-bit barrel
//               shifter; the granted request is shifted and registered into
//               a single tagged result slot with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        ReqV0,
    input  logic        ReqV1,
    output logic        ReqRdy0,
    output logic        ReqRdy1,
    input  logic [31:0] ReqX0,
    input  logic [31:0] ReqX1,
    input  logic [4:0]  ReqSa0,
    input  logic [4:0]  ReqSa1,
    input  logic        ReqArith0,
    input  logic        ReqArith1,
    input  logic        ReqRight0,
    input  logic        ReqRight1,
    output logic        RspV,
    input  logic        RspRdy,
    output logic [31:0] RspSh,
    output logic        RspId
);

    logic        r_rspv;
    logic [31:0] r_rspsh;
    logic        r_rspid;
    logic        r_prio;

    logic        w_free;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_sel;
    logic [31:0] w_x;
    logic [4:0]  w_sa;
    logic        w_arith;
    logic        w_right;
    logic [31:0] w_sh;

    // Grant: slot must be free; contention resolved by prio; nothing granted in reset
    always_comb begin
        w_free = ~r_rspv | RspRdy;
        w_gnt0 = Clrn & w_free & ReqV0 & (~ReqV1 | ~r_prio);
        w_gnt1 = Clrn & w_free & ReqV1 & (~ReqV0 |  r_prio);
        w_sel  = w_gnt1;
    end

    // Operand mux: only the granted requester's fields reach the shifter
    always_comb begin
        w_x     = w_sel ? ReqX1     : ReqX0;
        w_sa    = w_sel ? ReqSa1    : ReqSa0;
        w_arith = w_sel ? ReqArith1 : ReqArith0;
        w_right = w_sel ? ReqRight1 : ReqRight0;
    end

    // Shared barrel shifter; arith only matters for right shifts
    always_comb begin
        w_sh = w_x;
        if (!w_right) begin
            w_sh = w_x << w_sa;
        end else if (w_arith) begin
            w_sh = $signed(w_x) >>> w_sa;
        end else begin
            w_sh = w_x >> w_sa;
        end
    end

    // Result slot and priority pointer; a grant overwrites the slot even while it drains
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            r_rspv  <= 1'b0;
            r_rspsh <= 32'd0;
            r_rspid <= 1'b0;
            r_prio  <= RR_INIT;
        end else if (w_gnt0 | w_gnt1) begin
            r_rspv  <= 1'b1;
            r_rspsh <= w_sh;
            r_rspid <= w_sel;
            r_prio  <= ~w_sel;
        end else if (RspRdy) begin
            r_rspv  <= 1'b0;
        end
    end

    assign ReqRdy0 = w_gnt0;
    assign ReqRdy1 = w_gnt1;
    assign RspV    = r_rspv;
    assign RspSh   = r_rspsh;
    assign RspId   = r_rspid;

endmodule
`default_nettype wire

// File: tb/tb_shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shifter_arbiter
// Description : Directed, table-driven bench for shifter_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_arbiter;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic        ReqV0, ReqV1;
    logic        ReqRdy0, ReqRdy1;
    logic [31:0] ReqX0, ReqX1;
    logic [4:0]  ReqSa0, ReqSa1;
    logic        ReqArith0, ReqArith1;
    logic        ReqRight0, ReqRight1;
    logic        RspV;
    logic        RspRdy;
    logic [31:0] RspSh;
    logic        RspId;

    int checks = 0;
    int errors = 0;

    shifter_arbiter #(.RR_INIT(1'b0)) dut (
        .Clk(Clk), .Clrn(Clrn),
        .ReqV0(ReqV0), .ReqV1(ReqV1),
        .ReqRdy0(ReqRdy0), .ReqRdy1(ReqRdy1),
        .ReqX0(ReqX0), .ReqX1(ReqX1),
        .ReqSa0(ReqSa0), .ReqSa1(ReqSa1),
        .ReqArith0(ReqArith0), .ReqArith1(ReqArith1),
        .ReqRight0(ReqRight0), .ReqRight1(ReqRight1),
        .RspV(RspV), .RspRdy(RspRdy),
        .RspSh(RspSh), .RspId(RspId)
    );

    // 10 ns clock
    always #5 Clk = ~Clk;

    typedef struct {
        logic        sel;
        logic [31:0] x;
        logic [4:0]  sa;
        logic        arith;
        logic        right;
        logic        exp_rdy0;
        logic        exp_rdy1;
        logic [31:0] exp_sh;
        logic        exp_id;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_reqs();
        ReqV0 = 1'b0; ReqV1 = 1'b0;
        ReqX0 = 32'd0; ReqX1 = 32'd0;
        ReqSa0 = 5'd0; ReqSa1 = 5'd0;
        ReqArith0 = 1'b0; ReqArith1 = 1'b0;
        ReqRight0 = 1'b0; ReqRight1 = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [31:0] sh, input logic id);
        check({tag, "_v"},  {31'd0, RspV},  {31'd0, v});
        check({tag, "_sh"}, RspSh, sh);
        check({tag, "_id"}, {31'd0, RspId}, {31'd0, id});
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check({tag, "_rdy0"}, {31'd0, ReqRdy0}, {31'd0, r0});
        check({tag, "_rdy1"}, {31'd0, ReqRdy1}, {31'd0, r1});
    endtask

    initial begin
        //            sel  x             sa     ar    rt    rdy0  rdy1  exp_sh        id
        vecs[0] = '{1'b0, 32'h8000_00F0, 5'd4,  1'b1, 1'b1, 1'b1, 1'b0, 32'hF800_000F, 1'b0};
        vecs[1] = '{1'b0, 32'h8000_00F0, 5'd4,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0800_000F, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1};
        vecs[3] = '{1'b1, 32'h1234_5678, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 5'd8,  1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FF00, 1'b0};
        vecs[5] = '{1'b1, 32'h7000_0000, 5'd28, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0007, 1'b1};
        vecs[6] = '{1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0};

        // Reset with both requesters valid: nothing may be granted
        Clrn = 1'b0;
        RspRdy = 1'b1;
        idle_reqs();
        ReqV0 = 1'b1; ReqV1 = 1'b1;
        tick();
        tick();
        check_rdy("reset", 1'b0, 1'b0);
        check_rsp("reset", 1'b0, 32'd0, 1'b0);
        ReqV0 = 1'b0; ReqV1 = 1'b0;
        #1;
        check_rdy("reset_idle", 1'b0, 1'b0);
        Clrn = 1'b1;
        #1;
        check_rdy("idle", 1'b0, 1'b0);

        // Single-requester vectors, one per cycle with RspRdy high
        for (int i = 0; i < 7; i++) begin
            idle_reqs();
            if (vecs[i].sel) begin
                ReqV1 = 1'b1; ReqX1 = vecs[i].x; ReqSa1 = vecs[i].sa;
                ReqArith1 = vecs[i].arith; ReqRight1 = vecs[i].right;
            end else begin
                ReqV0 = 1'b1; ReqX0 = vecs[i].x; ReqSa0 = vecs[i].sa;
                ReqArith0 = vecs[i].arith; ReqRight0 = vecs[i].right;
            end
            #1;
            check_rdy($sformatf("vec%0d", i), vecs[i].exp_rdy0, vecs[i].exp_rdy1);
            tick();
            check_rsp($sformatf("vec%0d", i), 1'b1, vecs[i].exp_sh, vecs[i].exp_id);
        end
        idle_reqs();
        tick();
        check_rsp("drain", 1'b0, 32'hFFFF_FFFF, 1'b0);

        // Re-reset to restore prio = RR_INIT
        Clrn = 1'b0;
        tick();
        Clrn = 1'b1;

        // Continuous contention: grants alternate 0,1,0,1 with no bubbles
        ReqV0 = 1'b1; ReqX0 = 32'h0000_0001; ReqSa0 = 5'd1;
        ReqV1 = 1'b1; ReqX1 = 32'h0000_0010; ReqSa1 = 5'd4;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_rdy($sformatf("rr%0d", c), (c % 2) == 0, (c % 2) == 1);
            tick();
            check_rsp($sformatf("rr%0d", c), 1'b1,
                      ((c % 2) == 0) ? 32'h0000_0002 : 32'h0000_0100, (c % 2) == 1);
        end

        // Backpressure: slot held, no grants, result stable
        RspRdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_rdy($sformatf("bp%0d", c), 1'b0, 1'b0);
            tick();
            check_rsp($sformatf("bp%0d", c), 1'b1, 32'h0000_0100, 1'b1);
        end

        // Release: drain and load in one edge; prio untouched so requester 0 wins
        RspRdy = 1'b1;
        #1;
        check_rdy("release", 1'b1, 1'b0);
        tick();
        check_rsp("release", 1'b1, 32'h0000_0002, 1'b0);

        // Reset while a result is held and a grant (to requester 1) is pending
        #1;
        check_rdy("pre_rst", 1'b0, 1'b1);
        Clrn = 1'b0;
        #1;
        check_rdy("mid_rst", 1'b0, 1'b0);
        tick();
        check_rsp("mid_rst", 1'b0, 32'd0, 1'b0);
        Clrn = 1'b1;
        #1;
        check_rdy("post_rst", 1'b1, 1'b0);
        tick();
        check_rsp("post_rst", 1'b1, 32'h0000_0002, 1'b0);

        // Drain with no new grant: valid drops, data holds
        idle_reqs();
        tick();
        check_rsp("hold", 1'b0, 32'h0000_0002, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
